// File: rtl/seven_segment_capture.sv
// seven_segment_capture
//   Receive end of a multiplexed seven-segment display driver. Samples the active-low
//   segment/anode bus, filters out short transients, decodes each stable digit back to a
//   hex nibble plus decimal point, and publishes a full frame with a one-cycle valid pulse.
//   A frame ends when a digit already seen in the current frame is accepted again, or when
//   no digit has been accepted for TIMEOUT cycles (dark or stuck bus).
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low
//   seg[7:0]     segment bus, active-low; [7]=dp, [6:0]=g..a
//   an[3:0]      digit anodes, active-low; an[i]=0 selects digit i
//   hexnum[15:0] published digits, digit i at [4i+3:4i]
//   point[3:0]   published decimal points, 1 = lit
//   enable[3:0]  digits seen in the published frame
//   decode_err   published frame contained an illegal seg or an pattern
//   frame_valid  one-cycle pulse; outputs above update in this cycle
module seven_segment_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] hexnum,
  output logic [3:0]  point,
  output logic [3:0]  enable,
  output logic        decode_err,
  output logic        frame_valid
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IW = $clog2(TIMEOUT);

  localparam logic [SW-1:0] StableMax = SW'(STABLE_CYCLES);
  localparam logic [IW-1:0] IdleMax   = IW'(TIMEOUT - 1);

  // Returns {valid, nibble} for an active-low g..a pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    unique case (p)
      7'h40:   seg_decode = {1'b1, 4'h0};
      7'h79:   seg_decode = {1'b1, 4'h1};
      7'h24:   seg_decode = {1'b1, 4'h2};
      7'h30:   seg_decode = {1'b1, 4'h3};
      7'h19:   seg_decode = {1'b1, 4'h4};
      7'h12:   seg_decode = {1'b1, 4'h5};
      7'h02:   seg_decode = {1'b1, 4'h6};
      7'h78:   seg_decode = {1'b1, 4'h7};
      7'h00:   seg_decode = {1'b1, 4'h8};
      7'h10:   seg_decode = {1'b1, 4'h9};
      7'h08:   seg_decode = {1'b1, 4'hA};
      7'h03:   seg_decode = {1'b1, 4'hB};
      7'h46:   seg_decode = {1'b1, 4'hC};
      7'h21:   seg_decode = {1'b1, 4'hD};
      7'h06:   seg_decode = {1'b1, 4'hE};
      7'h0E:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  // Sample stage and previous sample for the stability filter.
  logic [7:0]    s_seg_q, p_seg_q;
  logic [3:0]    s_an_q, p_an_q;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  // Frame accumulator.
  logic [15:0] nib_acc_q, nib_acc_d;
  logic [3:0]  pt_acc_q, pt_acc_d;
  logic [3:0]  seen_q, seen_d;
  logic        err_acc_q, err_acc_d;

  logic [15:0] hexnum_d;
  logic [3:0]  point_d, enable_d;
  logic        decode_err_d, frame_valid_d;

  logic       stable_hit, one_low, multi_low, accept, multi_err, timeout, publish;
  logic [1:0] dig;
  logic [4:0] dec;

  always_comb begin
    one_low = 1'b1;
    dig     = 2'd0;
    unique case (s_an_q)
      4'b1110: dig = 2'd0;
      4'b1101: dig = 2'd1;
      4'b1011: dig = 2'd2;
      4'b0111: dig = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign multi_low = (s_an_q != 4'hF) && !one_low;
  assign dec       = seg_decode(s_seg_q[6:0]);

  always_comb begin
    if ((s_seg_q == p_seg_q) && (s_an_q == p_an_q)) begin
      stab_cnt_d = (stab_cnt_q == StableMax) ? stab_cnt_q : stab_cnt_q + 1'b1;
    end else begin
      stab_cnt_d = SW'(1);
    end
  end

  // Fires once per stable run: only on the transition into saturation.
  assign stable_hit = (stab_cnt_d == StableMax) && (stab_cnt_q != StableMax);
  assign accept     = stable_hit && one_low;
  assign multi_err  = stable_hit && multi_low;
  assign timeout    = !accept && (idle_cnt_q == IdleMax);
  assign publish    = (accept && seen_q[dig]) || timeout;

  always_comb begin
    nib_acc_d     = nib_acc_q;
    pt_acc_d      = pt_acc_q;
    seen_d        = seen_q;
    err_acc_d     = err_acc_q | multi_err;
    idle_cnt_d    = idle_cnt_q + 1'b1;
    hexnum_d      = hexnum;
    point_d       = point;
    enable_d      = enable;
    decode_err_d  = decode_err;
    frame_valid_d = publish;

    if (publish) begin
      hexnum_d     = nib_acc_q;
      point_d      = pt_acc_q;
      enable_d     = seen_q;
      decode_err_d = err_acc_q | multi_err;
      nib_acc_d    = '0;
      pt_acc_d     = '0;
      seen_d       = '0;
      err_acc_d    = 1'b0;
      idle_cnt_d   = '0;
    end

    if (accept) begin
      // Boundary accept: the accumulator was cleared above and restarts with this digit.
      nib_acc_d[{dig, 2'b00} +: 4] = dec[3:0];
      pt_acc_d[dig]                = ~s_seg_q[7];
      seen_d[dig]                  = 1'b1;
      err_acc_d                    = err_acc_d | ~dec[4];
      idle_cnt_d                   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_seg_q     <= 8'hFF;
      s_an_q      <= 4'hF;
      p_seg_q     <= 8'hFF;
      p_an_q      <= 4'hF;
      stab_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      nib_acc_q   <= '0;
      pt_acc_q    <= '0;
      seen_q      <= '0;
      err_acc_q   <= 1'b0;
      hexnum      <= '0;
      point       <= '0;
      enable      <= '0;
      decode_err  <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      s_seg_q     <= seg;
      s_an_q      <= an;
      p_seg_q     <= s_seg_q;
      p_an_q      <= s_an_q;
      stab_cnt_q  <= stab_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      nib_acc_q   <= nib_acc_d;
      pt_acc_q    <= pt_acc_d;
      seen_q      <= seen_d;
      err_acc_q   <= err_acc_d;
      hexnum      <= hexnum_d;
      point       <= point_d;
      enable      <= enable_d;
      decode_err  <= decode_err_d;
      frame_valid <= frame_valid_d;
    end
  end

endmodule
